watch_timer: RTL and testbench



---
 rtl/watch_timer_pkg.sv | 13 +
 rtl/watch_timer_if.sv | 21 ++
 rtl/watch_timer_bcd_stage.sv | 28 ++
 rtl/watch_timer.sv | 103 ++++++++++
 tb/tb_watch_timer.sv | 338 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/watch_timer_pkg.sv
// Shared definitions for the stopwatch time-keeping slice: lap state encodings
// and BCD digit limits.
package watch_timer_pkg;

  typedef enum logic {
    LIVE = 1'b0,
    HELD = 1'b1
  } lap_state_e;

  localparam logic [3:0] DEC_MAX = 4'd9;
  localparam logic [3:0] SEX_MAX = 4'd5;

endpackage

// File: rtl/watch_timer_if.sv
// Control/display bundle between the stopwatch button FSM, watch_timer and
// the display driver.
interface watch_timer_if;
  logic        WatchRunning;
  logic        WatchReset;
  logic        Lap;
  logic [23:0] Display;
  logic        Tick;
  logic        Held;
  logic        Overflow;

  modport master (
    output WatchRunning, WatchReset, Lap,
    input  Display, Tick, Held, Overflow
  );

  modport slave (
    input  WatchRunning, WatchReset, Lap,
    output Display, Tick, Held, Overflow
  );
endinterface

// File: rtl/watch_timer_bcd_stage.sv
// One BCD digit counting 0..MAX; CarryOut fires on the increment that wraps it
// so six of these chain into the mm:ss.hh counter.
module bcd_stage
  import watch_timer_pkg::*;
#(
  parameter logic [3:0] MAX = DEC_MAX
) (
  input  logic       Crystal,
  input  logic       nSysReset,
  input  logic       Clear,
  input  logic       Inc,
  output logic [3:0] Q,
  output logic       CarryOut
);

  always_ff @(posedge Crystal or negedge nSysReset) begin
    if (!nSysReset) begin
      Q <= 4'd0;
    end else if (Clear) begin
      Q <= 4'd0;
    end else if (Inc) begin
      Q <= (Q == MAX) ? 4'd0 : Q + 4'd1;
    end
  end

  assign CarryOut = Inc & (Q == MAX);

endmodule

// File: rtl/watch_timer.sv
// Stopwatch time-keeping datapath: prescaler, BCD mm:ss.hh counter, sticky
// overflow and a lap-hold freeze of the display.
module watch_timer
  import watch_timer_pkg::*;
#(
  parameter int TICK_DIV = 10,
  parameter int CNT_W    = 20
) (
  input  logic          Crystal,
  input  logic          nSysReset,
  watch_timer_if.slave  wt
);

  logic [CNT_W-1:0] Count;
  logic [23:0]      Time;
  logic [23:0]      LapTime;
  logic             LapPrev;
  logic             tick_end;
  logic             inc;
  logic [6:0]       carry;
  logic             lap_rise;
  logic             capture;
  logic             tick_q;
  logic             overflow_q;
  lap_state_e       state_q;
  lap_state_e       state_d;

  assign tick_end = (Count == CNT_W'(TICK_DIV - 1));
  assign inc      = wt.WatchRunning & ~wt.WatchReset & tick_end;
  assign lap_rise = wt.Lap & ~LapPrev;

  // Prescaler keeps its partial progress while paused.
  always_ff @(posedge Crystal or negedge nSysReset) begin
    if (!nSysReset) begin
      Count <= '0;
    end else if (wt.WatchReset) begin
      Count <= '0;
    end else if (wt.WatchRunning) begin
      Count <= tick_end ? '0 : Count + CNT_W'(1);
    end
  end

  // Digit chain, least significant first: H0 H1 S0 S1 M0 M1.
  assign carry[0] = inc;

  bcd_stage #(.MAX(DEC_MAX)) u_h0 (.Crystal, .nSysReset, .Clear(wt.WatchReset),
    .Inc(carry[0]), .Q(Time[3:0]),   .CarryOut(carry[1]));
  bcd_stage #(.MAX(DEC_MAX)) u_h1 (.Crystal, .nSysReset, .Clear(wt.WatchReset),
    .Inc(carry[1]), .Q(Time[7:4]),   .CarryOut(carry[2]));
  bcd_stage #(.MAX(DEC_MAX)) u_s0 (.Crystal, .nSysReset, .Clear(wt.WatchReset),
    .Inc(carry[2]), .Q(Time[11:8]),  .CarryOut(carry[3]));
  bcd_stage #(.MAX(SEX_MAX)) u_s1 (.Crystal, .nSysReset, .Clear(wt.WatchReset),
    .Inc(carry[3]), .Q(Time[15:12]), .CarryOut(carry[4]));
  bcd_stage #(.MAX(DEC_MAX)) u_m0 (.Crystal, .nSysReset, .Clear(wt.WatchReset),
    .Inc(carry[4]), .Q(Time[19:16]), .CarryOut(carry[5]));
  bcd_stage #(.MAX(SEX_MAX)) u_m1 (.Crystal, .nSysReset, .Clear(wt.WatchReset),
    .Inc(carry[5]), .Q(Time[23:20]), .CarryOut(carry[6]));

  always_ff @(posedge Crystal or negedge nSysReset) begin
    if (!nSysReset) begin
      tick_q     <= 1'b0;
      overflow_q <= 1'b0;
      LapPrev    <= 1'b0;
      LapTime    <= '0;
      state_q    <= LIVE;
    end else begin
      tick_q  <= inc;
      LapPrev <= wt.Lap;
      state_q <= state_d;
      if (wt.WatchReset) begin
        overflow_q <= 1'b0;
        LapTime    <= '0;
      end else begin
        if (carry[6]) overflow_q <= 1'b1;
        if (capture)  LapTime    <= Time;
      end
    end
  end

  // Lap toggle; a clear forces LIVE and swallows a coincident lap edge.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    if (wt.WatchReset) begin
      state_d = LIVE;
    end else if (lap_rise) begin
      case (state_q)
        LIVE: begin
          capture = 1'b1;
          state_d = HELD;
        end
        HELD:    state_d = LIVE;
        default: state_d = LIVE;
      endcase
    end
  end

  assign wt.Display  = (state_q == HELD) ? LapTime : Time;
  assign wt.Held     = (state_q == HELD);
  assign wt.Tick     = tick_q;
  assign wt.Overflow = overflow_q;

endmodule

// File: tb/tb_watch_timer.sv
// Bench for watch_timer: a hundredths-count reference model feeds an expected
// queue each clock, and every scenario pops and compares against the outputs.
module tb_watch_timer;

  localparam int DIV = 10;
  localparam int WRAP_T = 359999;

  logic Crystal = 1'b0;
  logic nSysReset = 1'b0;
  logic [23:0] pre_v;

  watch_timer_if wif();

  watch_timer #(.TICK_DIV(DIV), .CNT_W(20)) dut (
    .Crystal   (Crystal),
    .nSysReset (nSysReset),
    .wt        (wif)
  );

  always #5 Crystal = ~Crystal;

  typedef struct packed {
    logic [23:0] disp;
    logic        tick;
    logic        held;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  int m_cnt, m_t, m_lapt;
  bit m_held, m_ovf, m_tick, m_lapprev;
  int tests = 0;
  int fails = 0;

  function automatic logic [23:0] to_bcd(input int x);
    int m, s, h;
    m = x / 6000;
    s = (x / 100) % 60;
    h = x % 100;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(h / 10), 4'(h % 10)};
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_t = 0; m_lapt = 0;
    m_held = 0; m_ovf = 0; m_tick = 0; m_lapprev = 0;
  endtask

  // Advance one clock; the model sees the same inputs the DUT samples.
  task automatic cycle();
    bit run, clr, lap, lap_rise, inc;
    exp_t e;
    @(posedge Crystal);
    run = wif.WatchRunning; clr = wif.WatchReset; lap = wif.Lap;
    lap_rise = lap && !m_lapprev;
    inc = run && !clr && (m_cnt == DIV - 1);
    m_tick = inc;
    if (clr) begin
      m_cnt = 0; m_t = 0; m_lapt = 0; m_ovf = 0; m_held = 0;
    end else begin
      if (lap_rise) begin
        if (!m_held) begin
          m_lapt = m_t;
          m_held = 1;
        end else begin
          m_held = 0;
        end
      end
      if (run) m_cnt = (m_cnt == DIV - 1) ? 0 : m_cnt + 1;
      if (inc) begin
        if (m_t == WRAP_T) begin
          m_t = 0;
          m_ovf = 1;
        end else begin
          m_t++;
        end
      end
    end
    m_lapprev = lap;
    e.disp = m_held ? to_bcd(m_lapt) : to_bcd(m_t);
    e.tick = m_tick;
    e.held = m_held;
    e.ovf  = m_ovf;
    exp_q.push_back(e);
    @(negedge Crystal);
  endtask

  task preload(input logic [23:0] v, input int t);
    pre_v = v;
    force dut.u_h0.Q = pre_v[3:0];
    force dut.u_h1.Q = pre_v[7:4];
    force dut.u_s0.Q = pre_v[11:8];
    force dut.u_s1.Q = pre_v[15:12];
    force dut.u_m0.Q = pre_v[19:16];
    force dut.u_m1.Q = pre_v[23:20];
    #1;
    release dut.u_h0.Q;
    release dut.u_h1.Q;
    release dut.u_s0.Q;
    release dut.u_s1.Q;
    release dut.u_m0.Q;
    release dut.u_m1.Q;
    m_t = t;
  endtask

  task automatic test_reset();
    wif.WatchRunning = 1'b0; wif.WatchReset = 1'b0; wif.Lap = 1'b0;
    nSysReset = 1'b0;
    model_reset();
    #12;
    tests++;
    if (wif.Display !== 24'h000000 || wif.Tick !== 1'b0 || wif.Held !== 1'b0 || wif.Overflow !== 1'b0) begin
      fails++;
      $display("FAIL reset: got disp=%h tick=%b held=%b ovf=%b, want 000000 0 0 0",
               wif.Display, wif.Tick, wif.Held, wif.Overflow);
    end
    @(negedge Crystal);
    nSysReset = 1'b1;
  endtask

  task automatic test_first_tick();
    exp_t e;
    wif.WatchReset = 1'b1; wif.WatchRunning = 1'b0;
    cycle();
    void'(exp_q.pop_front());
    wif.WatchReset = 1'b0; wif.WatchRunning = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle();
      e = exp_q.pop_front();
      tests++;
      if (wif.Display !== e.disp || wif.Tick !== e.tick || wif.Held !== e.held || wif.Overflow !== e.ovf) begin
        fails++;
        $display("FAIL first_tick cyc %0d: got disp=%h tick=%b held=%b ovf=%b, want disp=%h tick=%b held=%b ovf=%b",
                 i, wif.Display, wif.Tick, wif.Held, wif.Overflow, e.disp, e.tick, e.held, e.ovf);
      end
      if (i == 9 || i == 10 || i == 11) begin
        tests++;
        if (wif.Display !== ((i == 9) ? 24'h000000 : 24'h000001) || wif.Tick !== (i == 10)) begin
          fails++;
          $display("FAIL first_tick_edge cyc %0d: got disp=%h tick=%b", i, wif.Display, wif.Tick);
        end
      end
    end
  endtask

  task automatic test_pause();
    exp_t e;
    wif.WatchReset = 1'b1; wif.WatchRunning = 1'b0;
    cycle();
    void'(exp_q.pop_front());
    wif.WatchReset = 1'b0;
    for (int i = 0; i < 30; i++) begin
      wif.WatchRunning = (i < 5 || i >= 25);
      cycle();
      e = exp_q.pop_front();
      tests++;
      if (wif.Display !== e.disp || wif.Tick !== e.tick || wif.Overflow !== e.ovf) begin
        fails++;
        $display("FAIL pause cyc %0d: got disp=%h tick=%b ovf=%b, want disp=%h tick=%b ovf=%b",
                 i, wif.Display, wif.Tick, wif.Overflow, e.disp, e.tick, e.ovf);
      end
    end
    tests++;
    if (wif.Display !== 24'h000001) begin
      fails++;
      $display("FAIL pause_resume: got disp=%h, want 000001", wif.Display);
    end
  endtask

  task automatic test_wrap();
    exp_t e;
    wif.WatchReset = 1'b1; wif.WatchRunning = 1'b0;
    cycle();
    void'(exp_q.pop_front());
    wif.WatchReset = 1'b0;
    preload(24'h005999, 5999);
    wif.WatchRunning = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      e = exp_q.pop_front();
      tests++;
      if (wif.Display !== e.disp || wif.Tick !== e.tick || wif.Overflow !== e.ovf) begin
        fails++;
        $display("FAIL minute_carry cyc %0d: got disp=%h tick=%b ovf=%b, want disp=%h tick=%b ovf=%b",
                 i, wif.Display, wif.Tick, wif.Overflow, e.disp, e.tick, e.ovf);
      end
    end
    tests++;
    if (wif.Display !== 24'h010000 || wif.Overflow !== 1'b0) begin
      fails++;
      $display("FAIL minute_carry_val: got disp=%h ovf=%b, want 010000 0", wif.Display, wif.Overflow);
    end
    wif.WatchRunning = 1'b0;
    preload(24'h595999, WRAP_T);
    wif.WatchRunning = 1'b1;
    for (int i = 0; i < 25; i++) begin
      cycle();
      e = exp_q.pop_front();
      tests++;
      if (wif.Display !== e.disp || wif.Tick !== e.tick || wif.Overflow !== e.ovf) begin
        fails++;
        $display("FAIL wrap cyc %0d: got disp=%h tick=%b ovf=%b, want disp=%h tick=%b ovf=%b",
                 i, wif.Display, wif.Tick, wif.Overflow, e.disp, e.tick, e.ovf);
      end
      if (i == 9) begin
        tests++;
        if (wif.Display !== 24'h000000 || wif.Overflow !== 1'b1) begin
          fails++;
          $display("FAIL wrap_val: got disp=%h ovf=%b, want 000000 1", wif.Display, wif.Overflow);
        end
      end
    end
    wif.WatchReset = 1'b1;
    cycle();
    e = exp_q.pop_front();
    tests++;
    if (wif.Overflow !== e.ovf || wif.Display !== e.disp) begin
      fails++;
      $display("FAIL ovf_clear: got ovf=%b disp=%h, want ovf=%b disp=%h", wif.Overflow, wif.Display, e.ovf, e.disp);
    end
    wif.WatchReset = 1'b0;
  endtask

  task automatic test_lap();
    exp_t e;
    int budget;
    wif.WatchRunning = 1'b1;
    budget = 0;
    while (m_t != 7 && budget < 200) begin
      cycle();
      void'(exp_q.pop_front());
      budget++;
    end
    tests++;
    if (m_t != 7) begin
      fails++;
      $display("FAIL lap_setup: timed out, model time %0d, want 7", m_t);
    end
    for (int i = 0; i < 44; i++) begin
      wif.Lap = (i == 0 || i == 30);
      cycle();
      e = exp_q.pop_front();
      tests++;
      if (wif.Display !== e.disp || wif.Held !== e.held || wif.Tick !== e.tick) begin
        fails++;
        $display("FAIL lap cyc %0d: got disp=%h held=%b tick=%b, want disp=%h held=%b tick=%b",
                 i, wif.Display, wif.Held, wif.Tick, e.disp, e.held, e.tick);
      end
      if (i == 29) begin
        tests++;
        if (wif.Held !== 1'b1 || wif.Display !== 24'h000007) begin
          fails++;
          $display("FAIL lap_freeze: got held=%b disp=%h, want 1 000007", wif.Held, wif.Display);
        end
      end
    end
    tests++;
    if (wif.Held !== 1'b0 || wif.Display !== to_bcd(m_t)) begin
      fails++;
      $display("FAIL lap_release: got held=%b disp=%h, want 0 %h", wif.Held, wif.Display, to_bcd(m_t));
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 34; i++) begin
      wif.Lap        = (i < 30) || (i == 32) || (i == 33);
      wif.WatchReset = (i == 31) || (i == 32);
      cycle();
      e = exp_q.pop_front();
      tests++;
      if (wif.Display !== e.disp || wif.Held !== e.held || wif.Overflow !== e.ovf) begin
        fails++;
        $display("FAIL lap_level cyc %0d: got disp=%h held=%b ovf=%b, want disp=%h held=%b ovf=%b",
                 i, wif.Display, wif.Held, wif.Overflow, e.disp, e.held, e.ovf);
      end
      if (i == 29 || i == 32) begin
        tests++;
        if (wif.Held !== (i == 29) || (i == 32 && wif.Display !== 24'h000000)) begin
          fails++;
          $display("FAIL lap_toggle cyc %0d: got held=%b disp=%h", i, wif.Held, wif.Display);
        end
      end
    end
    wif.Lap = 1'b0; wif.WatchReset = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t e;
    wif.WatchRunning = 1'b1;
    for (int i = 0; i < 40; i++) begin
      wif.Lap = (i == 20);
      cycle();
      void'(exp_q.pop_front());
    end
    tests++;
    if (wif.Held !== 1'b1 || wif.Display === 24'h000000) begin
      fails++;
      $display("FAIL async_setup: got held=%b disp=%h, want held=1 and nonzero", wif.Held, wif.Display);
    end
    #2;
    nSysReset = 1'b0;
    #1;
    tests++;
    if (wif.Display !== 24'h000000 || wif.Tick !== 1'b0 || wif.Held !== 1'b0 || wif.Overflow !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: got disp=%h tick=%b held=%b ovf=%b, want 000000 0 0 0",
               wif.Display, wif.Tick, wif.Held, wif.Overflow);
    end
    model_reset();
    @(negedge Crystal);
    @(negedge Crystal);
    nSysReset = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      cycle();
      e = exp_q.pop_front();
      tests++;
      if (wif.Display !== e.disp || wif.Tick !== e.tick || wif.Held !== e.held) begin
        fails++;
        $display("FAIL post_reset cyc %0d: got disp=%h tick=%b held=%b, want disp=%h tick=%b held=%b",
                 i, wif.Display, wif.Tick, wif.Held, e.disp, e.tick, e.held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_pause();
    test_wrap();
    test_lap();
    test_back_to_back();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
